// File: rtl/mac_result_drain_pkg.sv
// Shared constants, mode/state encodings and lane-sequencing helpers for the
// MAC result drain.
package mac_result_drain_pkg;

  localparam int MAC_ACC_WIDTH    = 32;
  localparam int MAC_DRAIN_DEPTH  = 2;
  localparam int MAC_DRAIN_DROP_W = 8;

  typedef enum logic [1:0] {
    MAC_MODE_SINGLE = 2'b00,
    MAC_MODE_DUAL   = 2'b01,
    MAC_MODE_QUAD   = 2'b10,
    MAC_MODE_RSVD   = 2'b11
  } mac_mode_e;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_SEND = 1'b1
  } drain_state_e;

  // Reserved mode falls into the default arm and behaves like single.
  function automatic logic [1:0] mode_last_lane(input logic [1:0] mode);
    case (mac_mode_e'(mode))
      MAC_MODE_DUAL: mode_last_lane = 2'd2;
      MAC_MODE_QUAD: mode_last_lane = 2'd0;
      default:       mode_last_lane = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] mode_lane_step(input logic [1:0] mode);
    case (mac_mode_e'(mode))
      MAC_MODE_DUAL: mode_lane_step = 2'd2;
      default:       mode_lane_step = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/mac_snap_fifo.sv
// Synchronous snapshot FIFO with extra-MSB pointers and a combinational head
// read; push and pop may occur together, including while full.
module mac_snap_fifo #(
  parameter  int WIDTH = 130,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // live, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the four MAC cluster accumulators on capture and serialises the
// lanes meaningful for each snapshot's mode onto a valid/ready stream.
module mac_result_drain
  import mac_result_drain_pkg::*;
#(
  parameter  int ACC_W  = MAC_ACC_WIDTH,
  parameter  int DEPTH  = MAC_DRAIN_DEPTH,
  parameter  int DROP_W = MAC_DRAIN_DROP_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int SNAP_W = 4 * ACC_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              capture,
  input  logic [ACC_W-1:0]  in0,
  input  logic [ACC_W-1:0]  in1,
  input  logic [ACC_W-1:0]  in2,
  input  logic [ACC_W-1:0]  in3,
  output logic              capture_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [1:0]        m_lane,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [AW:0] COUNT_ONE = 1;

  drain_state_e      r_state;
  drain_state_e      w_state_nxt;
  logic [1:0]        r_lane;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_count;

  logic [SNAP_W-1:0] w_wdata;
  logic [SNAP_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic [1:0]        w_head_mode;
  logic [ACC_W-1:0]  w_lane_data;
  logic              w_fire;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_wdata = {mode, in3, in2, in1, in0};

  mac_snap_fifo #(
    .WIDTH (SNAP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_mode = w_head[4*ACC_W +: 2];

  always_comb begin
    w_lane_data = w_head[0 +: ACC_W];
    case (r_lane)
      2'd1:    w_lane_data = w_head[ACC_W   +: ACC_W];
      2'd2:    w_lane_data = w_head[2*ACC_W +: ACC_W];
      2'd3:    w_lane_data = w_head[3*ACC_W +: ACC_W];
      default: w_lane_data = w_head[0 +: ACC_W];
    endcase
  end

  // Beat outputs come straight from the head entry and lane pointer, so they
  // hold by construction while the sink stalls.
  assign m_valid = (r_state == DRAIN_SEND);
  assign m_data  = m_valid ? w_lane_data : '0;
  assign m_lane  = m_valid ? r_lane : 2'd0;
  assign m_last  = m_valid && (r_lane == mode_last_lane(w_head_mode));

  assign w_fire        = m_valid && m_ready;
  assign w_pop         = w_fire && m_last;
  assign capture_ready = !w_full || w_pop;
  assign w_push        = capture && capture_ready;
  assign w_drop        = capture && !capture_ready;
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

  // NOTE: the next-state default comes first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DRAIN_IDLE: if (w_push) w_state_nxt = DRAIN_SEND;
      DRAIN_SEND: if (w_pop && !w_push && (w_count == COUNT_ONE))
                    w_state_nxt = DRAIN_IDLE;
      default:    w_state_nxt = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= DRAIN_IDLE;
      r_lane       <= 2'd0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_lane <= 2'd0;
      end else if (w_fire) begin
        r_lane <= r_lane + mode_lane_step(w_head_mode);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != {DROP_W{1'b1}}) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: lane sequencing per mode, backpressure,
// overflow accounting, full-with-pop capture and synchronous reset mid-drain.
module tb_mac_result_drain;
  import mac_result_drain_pkg::*;

  localparam int ACC_W  = MAC_ACC_WIDTH;
  localparam int DEPTH  = 2;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              capture;
  logic [ACC_W-1:0]  in0, in1, in2, in3;
  logic              capture_ready;
  logic [ACC_W-1:0]  m_data;
  logic [1:0]        m_lane;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  int total = 0;
  int bad   = 0;

  mac_result_drain #(.ACC_W(ACC_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .capture       (capture),
    .in0           (in0),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .capture_ready (capture_ready),
    .m_data        (m_data),
    .m_lane        (m_lane),
    .m_last        (m_last),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the
  // falling edge of the same cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_capture(input logic [1:0] md, input int a, input int b,
                             input int c, input int d);
    mode    = md;
    in0     = ACC_W'(a);
    in1     = ACC_W'(b);
    in2     = ACC_W'(c);
    in3     = ACC_W'(d);
    capture = 1'b1;
  endtask

  task automatic do_reset();
    capture = 1'b0;
    rst     = 1'b1;
    cyc();
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    settle();
    total++;
    if ({m_valid, m_lane, m_last} !== 4'b0) begin
      bad++;
      $display("FAIL reset_beat: got v=%0b lane=%0d last=%0b, want all 0", m_valid, m_lane, m_last);
    end
    total++;
    if (m_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got %0d want 0", m_data);
    end
    total++;
    if ({overflow, drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_drop: got ovf=%0b cnt=%0d want 0/0", overflow, drop_count);
    end
    total++;
    if (capture_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_capture_ready: got %0b want 1", capture_ready);
    end
    cyc();
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    set_capture(MAC_MODE_SINGLE, 1, 2, 3, 4);
    settle();
    total++;
    if ({m_valid, capture_ready} !== 2'b01) begin
      bad++;
      $display("FAIL single_idle: got v=%0b rdy=%0b want v=0 rdy=1", m_valid, capture_ready);
    end
    cyc();
    capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(i), 1'(i == 3)} || m_data !== ACC_W'(i + 1)) begin
        bad++;
        $display("FAIL single_beat%0d: got v=%0b lane=%0d last=%0b data=%0d want v=1 lane=%0d last=%0b data=%0d",
                 i, m_valid, m_lane, m_last, m_data, i, (i == 3), i + 1);
      end
      cyc();
    end
    settle();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_end: got v=%0b want 0", m_valid);
    end
    cyc();
  endtask

  task automatic test_dual_quad();
    int el[3] = '{0, 2, 0};
    int ed[3] = '{10, 30, 50};
    bit ex[3] = '{1'b0, 1'b1, 1'b1};
    m_ready = 1'b1;
    set_capture(MAC_MODE_DUAL, 10, 20, 30, 40);
    cyc();
    set_capture(MAC_MODE_QUAD, 50, 60, 70, 80);
    for (int k = 0; k < 3; k++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(el[k]), ex[k]} || m_data !== ACC_W'(ed[k])) begin
        bad++;
        $display("FAIL dualquad_beat%0d: got v=%0b lane=%0d last=%0b data=%0d want v=1 lane=%0d last=%0b data=%0d",
                 k, m_valid, m_lane, m_last, m_data, el[k], ex[k], ed[k]);
      end
      cyc();
      capture = 1'b0;
    end
    settle();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL dualquad_end: got v=%0b want 0", m_valid);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    set_capture(MAC_MODE_SINGLE, 5, 6, 7, 8);
    cyc();
    capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== 4'b1000 || m_data !== ACC_W'(5)) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%0b lane=%0d last=%0b data=%0d want v=1 lane=0 last=0 data=5",
                 i, m_valid, m_lane, m_last, m_data);
      end
      cyc();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(i), 1'(i == 3)} || m_data !== ACC_W'(i + 5)) begin
        bad++;
        $display("FAIL bp_beat%0d: got v=%0b lane=%0d last=%0b data=%0d want lane=%0d data=%0d",
                 i, m_valid, m_lane, m_last, m_data, i, i + 5);
      end
      cyc();
    end
    settle();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_end: got v=%0b want 0", m_valid);
    end
    cyc();
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    set_capture(MAC_MODE_SINGLE, 11, 12, 13, 14);
    cyc();
    set_capture(MAC_MODE_SINGLE, 21, 22, 23, 24);
    settle();
    total++;
    if (capture_ready !== 1'b1) begin
      bad++;
      $display("FAIL ovf_second_ready: got %0b want 1", capture_ready);
    end
    cyc();
    set_capture(MAC_MODE_SINGLE, 31, 32, 33, 34);
    settle();
    total++;
    if ({capture_ready, overflow} !== 2'b00) begin
      bad++;
      $display("FAIL ovf_full: got rdy=%0b ovf=%0b want 0/0", capture_ready, overflow);
    end
    cyc();
    set_capture(MAC_MODE_SINGLE, 41, 42, 43, 44);
    settle();
    total++;
    if ({overflow, drop_count} !== {1'b1, 8'd1}) begin
      bad++;
      $display("FAIL ovf_first_drop: got ovf=%0b cnt=%0d want 1/1", overflow, drop_count);
    end
    cyc();
    capture = 1'b0;
    settle();
    total++;
    if ({overflow, drop_count} !== {1'b1, 8'd2}) begin
      bad++;
      $display("FAIL ovf_second_drop: got ovf=%0b cnt=%0d want 1/2", overflow, drop_count);
    end
    cyc();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(i % 4), 1'(i % 4 == 3)} ||
          m_data !== ACC_W'((i < 4 ? 11 : 17) + i)) begin
        bad++;
        $display("FAIL ovf_drain%0d: got v=%0b lane=%0d last=%0b data=%0d want lane=%0d data=%0d",
                 i, m_valid, m_lane, m_last, m_data, i % 4, (i < 4 ? 11 : 17) + i);
      end
      cyc();
    end
    settle();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_end: got v=%0b want 0", m_valid);
    end
    cyc();
  endtask

  task automatic test_full_pop_push();
    int el[6] = '{0, 2, 0, 1, 2, 3};
    int ed[6] = '{200, 202, 300, 301, 302, 303};
    bit ex[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    m_ready = 1'b0;
    set_capture(MAC_MODE_QUAD, 100, 101, 102, 103);
    cyc();
    set_capture(MAC_MODE_DUAL, 200, 201, 202, 203);
    cyc();
    capture = 1'b0;
    settle();
    total++;
    if ({capture_ready, m_valid, m_last} !== 3'b011 || m_data !== ACC_W'(100)) begin
      bad++;
      $display("FAIL fpp_full: got rdy=%0b v=%0b last=%0b data=%0d want rdy=0 v=1 last=1 data=100",
               capture_ready, m_valid, m_last, m_data);
    end
    cyc();
    m_ready = 1'b1;
    set_capture(MAC_MODE_SINGLE, 300, 301, 302, 303);
    settle();
    total++;
    if (capture_ready !== 1'b1) begin
      bad++;
      $display("FAIL fpp_ready: got %0b want 1", capture_ready);
    end
    cyc();
    capture = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(el[k]), ex[k]} || m_data !== ACC_W'(ed[k])) begin
        bad++;
        $display("FAIL fpp_beat%0d: got v=%0b lane=%0d last=%0b data=%0d want lane=%0d last=%0b data=%0d",
                 k, m_valid, m_lane, m_last, m_data, el[k], ex[k], ed[k]);
      end
      cyc();
    end
    settle();
    total++;
    if ({m_valid, overflow, drop_count} !== '0) begin
      bad++;
      $display("FAIL fpp_end: got v=%0b ovf=%0b cnt=%0d want 0/0/0", m_valid, overflow, drop_count);
    end
    cyc();
  endtask

  task automatic test_reset_mid_drain();
    m_ready = 1'b0;
    set_capture(MAC_MODE_SINGLE, 41, 42, 43, 44);
    cyc();
    set_capture(MAC_MODE_SINGLE, 61, 62, 63, 64);
    cyc();
    set_capture(MAC_MODE_SINGLE, 71, 72, 73, 74);
    cyc();
    capture = 1'b0;
    m_ready = 1'b1;
    cyc();
    settle();
    total++;
    if ({m_valid, m_lane, overflow} !== 4'b1011 || m_data !== ACC_W'(42)) begin
      bad++;
      $display("FAIL rmd_lane1: got v=%0b lane=%0d ovf=%0b data=%0d want v=1 lane=1 ovf=1 data=42",
               m_valid, m_lane, overflow, m_data);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    total++;
    if ({m_valid, m_lane, m_last, overflow, capture_ready} !== 6'b000001 ||
        drop_count !== '0 || m_data !== '0) begin
      bad++;
      $display("FAIL rmd_after_reset: got v=%0b lane=%0d last=%0b ovf=%0b rdy=%0b cnt=%0d data=%0d want 0/0/0/0/1/0/0",
               m_valid, m_lane, m_last, overflow, capture_ready, drop_count, m_data);
    end
    cyc();
    set_capture(MAC_MODE_SINGLE, 51, 52, 53, 54);
    cyc();
    capture = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if ({m_valid, m_lane, m_last} !== {1'b1, 2'(i), 1'(i == 3)} || m_data !== ACC_W'(i + 51)) begin
        bad++;
        $display("FAIL rmd_beat%0d: got v=%0b lane=%0d last=%0b data=%0d want lane=%0d data=%0d",
                 i, m_valid, m_lane, m_last, m_data, i, i + 51);
      end
      cyc();
    end
    settle();
    total++;
    if (m_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmd_end: got v=%0b want 0", m_valid);
    end
    cyc();
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 2'b00;
    capture = 1'b0;
    in0     = '0;
    in1     = '0;
    in2     = '0;
    in3     = '0;
    m_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    test_reset();
    test_single();
    test_dual_quad();
    test_backpressure();
    test_overflow();
    do_reset();
    test_full_pop_push();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
